seq_divider: RTL and testbench

//  Iterative unsigned restoring divider, the inverse datapath of the shift-add multiplier.

---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 107 ++++++++++
 tb/tb_seq_divider.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and result bundle between the lab top and the sequential divider.
// The master side drives the synchronized switches and buttons; the slave side returns registered results.
interface seq_divider_if #(
   parameter int WIDTH = 8
);
   logic             run;
   logic             load_d;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dval;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output run, load_d, din,
      input  quot, rem, dval, busy, done, div_zero
   );

   modport slave (
      input  run, load_d, din,
      output quot, rem, dval, busy, done, div_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, WIDTH clocks per division.
// The divisor is loaded separately; a held Run level starts exactly one division.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input logic         clk,
   input logic         rst,
   seq_divider_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dval;
   logic [CW-1:0]    count;
   logic             div_zero;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // DONE waits for Run to drop so a held button never retriggers a division.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.run && !bus.load_d) begin
               state_nxt = COMPUTE;
            end
         end
         COMPUTE: begin
            if (count == LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (!bus.run) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Trial subtraction one bit wider than the operands; its MSB is the borrow.
   always_comb begin
      trial = {rem, quot[WIDTH-1]};
      diff  = trial - {1'b0, dval};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quot     <= '0;
         rem      <= '0;
         dval     <= '0;
         count    <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.load_d) begin
                  dval <= bus.din;
               end else if (bus.run) begin
                  quot     <= bus.din;
                  rem      <= '0;
                  count    <= '0;
                  div_zero <= (dval == '0);
               end
            end
            COMPUTE: begin
               if (!diff[WIDTH]) begin
                  rem  <= diff[WIDTH-1:0];
                  quot <= {quot[WIDTH-2:0], 1'b1};
               end else begin
                  rem  <= trial[WIDTH-1:0];
                  quot <= {quot[WIDTH-2:0], 1'b0};
               end
               count <= count + CW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.quot     = quot;
   assign bus.rem      = rem;
   assign bus.dval     = dval;
   assign bus.div_zero = div_zero;
   assign bus.busy     = (state == COMPUTE);
   assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider with hand-computed quotients and remainders.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seq_divider;
   localparam int WIDTH = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   busy_cycles;
   bit   got_done;
   bit   saw_busy;

   seq_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_divider #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic run_v, input logic load_v, input logic [WIDTH-1:0] din_v);
      @(negedge clk);
      bus.run    = run_v;
      bus.load_d = load_v;
      bus.din    = din_v;
   endtask

   task automatic set_divisor(input logic [WIDTH-1:0] d);
      apply_stimulus(1'b0, 1'b1, d);
      apply_stimulus(1'b0, 1'b0, '0);
      check_output("dval_load", 32'(bus.dval), 32'(d));
   endtask

   // Waits (bounded) for Done, counting the falling edges on which Busy is seen.
   task automatic wait_done();
      busy_cycles = 0;
      got_done    = 1'b0;
      for (int i = 0; i < 40 && !got_done; i++) begin
         @(negedge clk);
         if (bus.busy) busy_cycles++;
         if (bus.done) got_done = 1'b1;
      end
   endtask

   task automatic run_div(input string tag, input logic [WIDTH-1:0] dividend,
                          input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r,
                          input logic exp_dz);
      apply_stimulus(1'b1, 1'b0, dividend);
      wait_done();
      check_output({tag, "_done"}, 32'(got_done), 32'd1);
      check_output({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(WIDTH));
      check_output({tag, "_quot"}, 32'(bus.quot), 32'(exp_q));
      check_output({tag, "_rem"}, 32'(bus.rem), 32'(exp_r));
      check_output({tag, "_divzero"}, 32'(bus.div_zero), 32'(exp_dz));
      apply_stimulus(1'b0, 1'b0, '0);
      @(negedge clk);
      check_output({tag, "_idle_done"}, 32'(bus.done), 32'd0);
      check_output({tag, "_hold_quot"}, 32'(bus.quot), 32'(exp_q));
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      bus.run    = 1'b0;
      bus.load_d = 1'b0;
      bus.din    = '0;
      #12;
      check_output("reset_quot", 32'(bus.quot), 32'd0);
      check_output("reset_rem", 32'(bus.rem), 32'd0);
      check_output("reset_dval", 32'(bus.dval), 32'd0);
      check_output("reset_busy", 32'(bus.busy), 32'd0);
      check_output("reset_done", 32'(bus.done), 32'd0);
      check_output("reset_divzero", 32'(bus.div_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] basic divisions");
      set_divisor(8'd7);
      run_div("d100_7", 8'd100, 8'd14, 8'd2, 1'b0);
      set_divisor(8'd1);
      run_div("d255_1", 8'd255, 8'd255, 8'd0, 1'b0);
      set_divisor(8'd255);
      run_div("d255_255", 8'd255, 8'd1, 8'd0, 1'b0);
      set_divisor(8'd9);
      run_div("d5_9", 8'd5, 8'd0, 8'd5, 1'b0);
      set_divisor(8'd0);
      run_div("d200_0", 8'd200, 8'd255, 8'd200, 1'b1);
      set_divisor(8'd3);
      run_div("d128_3", 8'd128, 8'd42, 8'd2, 1'b0);

      $display("[TB] held Run and LoadD during compute");
      set_divisor(8'd6);
      apply_stimulus(1'b1, 1'b0, 8'd50);
      apply_stimulus(1'b1, 1'b0, 8'd50);
      apply_stimulus(1'b1, 1'b1, 8'd3);
      apply_stimulus(1'b1, 1'b0, 8'd50);
      check_output("compute_dval_frozen", 32'(bus.dval), 32'd6);
      wait_done();
      check_output("hold_done", 32'(got_done), 32'd1);
      check_output("hold_quot", 32'(bus.quot), 32'd8);
      check_output("hold_rem", 32'(bus.rem), 32'd2);
      saw_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.busy || !bus.done) saw_busy = 1'b1;
      end
      check_output("hold_no_rerun", 32'(saw_busy), 32'd0);
      check_output("hold_quot_after", 32'(bus.quot), 32'd8);
      apply_stimulus(1'b0, 1'b0, '0);
      @(negedge clk);
      check_output("release_done", 32'(bus.done), 32'd0);
      run_div("rerun_d47_6", 8'd47, 8'd7, 8'd5, 1'b0);

      $display("[TB] LoadD and Run together");
      apply_stimulus(1'b1, 1'b1, 8'd10);
      apply_stimulus(1'b1, 1'b0, 8'd73);
      check_output("same_cycle_dval", 32'(bus.dval), 32'd10);
      check_output("same_cycle_not_busy", 32'(bus.busy), 32'd0);
      wait_done();
      check_output("same_cycle_done", 32'(got_done), 32'd1);
      check_output("same_cycle_busy_cycles", 32'(busy_cycles), 32'(WIDTH));
      check_output("same_cycle_quot", 32'(bus.quot), 32'd7);
      check_output("same_cycle_rem", 32'(bus.rem), 32'd3);
      apply_stimulus(1'b0, 1'b0, '0);
      @(negedge clk);

      $display("[TB] reset during compute");
      set_divisor(8'd5);
      apply_stimulus(1'b1, 1'b0, 8'd200);
      for (int i = 0; i < 4; i++) @(negedge clk);
      check_output("pre_reset_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      check_output("async_reset_quot", 32'(bus.quot), 32'd0);
      check_output("async_reset_rem", 32'(bus.rem), 32'd0);
      check_output("async_reset_dval", 32'(bus.dval), 32'd0);
      check_output("async_reset_busy", 32'(bus.busy), 32'd0);
      bus.run = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      set_divisor(8'd6);
      run_div("post_reset_d77_6", 8'd77, 8'd12, 8'd5, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
